// File: rtl/sram_ctrl32.sv
// sram_ctrl32: turns one 32-bit word request from the MEM stage into two
// 16-bit accesses (low half, then high half) on a 256K x 16 external SRAM.
// ready is low while an access is in flight and freezes the pipeline.
// Optional macro SRAM_ADDR_CHECK_EN: reject out-of-range requests and flag
// them on addr_err instead of wrapping the halfword address.
module sram_ctrl32 #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        addr_err,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Counter preload; guarded so a zero wait count never underflows the constant.
  localparam logic [2:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t      state_r;
  logic        op_wr_r;
  logic [16:0] widx_r;
  logic [15:0] wdata_hi_r;
  logic [31:0] rdata_r;
  logic [2:0]  cnt_r;
  logic        we_n_r;
  logic [17:0] addr_r;
  logic        dq_oe_r;
  logic [15:0] dq_out_r;
  logic        err_r;

  logic        req_s;
  logic [31:0] offset_s;
  logic [16:0] widx_s;
  logic        reject_s;
  logic        ready_s;
  logic        unused_s;

  assign req_s    = rd_en | wr_en;
  // 32-bit subtraction so addresses below the base wrap before truncation.
  assign offset_s = address - BASE_ADDR;
  assign widx_s   = offset_s[18:2];

`ifdef SRAM_ADDR_CHECK_EN
  // Below the base shows up as a huge offset, so one upper-bits test covers both limits.
  assign reject_s = (address < BASE_ADDR) || (offset_s[31:19] != 13'd0);
  assign unused_s = ^offset_s[1:0];
`else
  assign reject_s = 1'b0;
  assign unused_s = ^{offset_s[31:19], offset_s[1:0]};
`endif

  // Sequencer: latches the request, drives the SRAM pins from registers and captures read halves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      op_wr_r    <= 1'b0;
      widx_r     <= 17'd0;
      wdata_hi_r <= 16'd0;
      rdata_r    <= 32'd0;
      cnt_r      <= 3'd0;
      we_n_r     <= 1'b1;
      addr_r     <= 18'd0;
      dq_oe_r    <= 1'b0;
      dq_out_r   <= 16'd0;
      err_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_s && reject_s) begin
            state_r <= ST_DONE;
            err_r   <= 1'b1;
          end else if (req_s) begin
            // Write wins when both enables are high.
            state_r    <= ST_LO;
            op_wr_r    <= wr_en;
            widx_r     <= widx_s;
            wdata_hi_r <= wdata[31:16];
            addr_r     <= {widx_s, 1'b0};
            we_n_r     <= ~wr_en;
            dq_oe_r    <= wr_en;
            dq_out_r   <= wdata[15:0];
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LO: begin
          if (!op_wr_r) begin
            rdata_r[15:0] <= SRAM_DQ;
          end else begin
            rdata_r[15:0] <= rdata_r[15:0];
          end
          state_r  <= ST_HI;
          addr_r   <= {widx_r, 1'b1};
          dq_out_r <= wdata_hi_r;
        end
        ST_HI: begin
          if (!op_wr_r) begin
            rdata_r[31:16] <= SRAM_DQ;
          end else begin
            rdata_r[31:16] <= rdata_r[31:16];
          end
          we_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
          if (WAIT_CYCLES > 0) begin
            state_r <= ST_WAIT;
            cnt_r   <= WAIT_LOAD;
          end else begin
            state_r <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == 3'd0) begin
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end
        ST_DONE: begin
          // A request still present here counts as consumed.
          state_r <= ST_IDLE;
          err_r   <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          we_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
          err_r   <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline freeze: low from the accepting IDLE cycle until DONE.
  always_comb begin
    ready_s = 1'b1;
    case (state_r)
      ST_IDLE: ready_s = ~req_s;
      ST_LO:   ready_s = 1'b0;
      ST_HI:   ready_s = 1'b0;
      ST_WAIT: ready_s = 1'b0;
      ST_DONE: ready_s = 1'b1;
      default: ready_s = 1'b1;
    endcase
  end

  assign ready     = ready_s;
  assign rdata     = rdata_r;
  assign SRAM_DQ   = dq_oe_r ? dq_out_r : 16'bz;
  assign SRAM_ADDR = addr_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

`ifdef SRAM_ADDR_CHECK_EN
  assign addr_err = err_r;
`else
  assign addr_err = 1'b0;
`endif

endmodule
